// File: rtl/seq_det_arbiter.sv
// Round-robin scheduler sharing one 101001 detector across N_CH serial streams.
// State | meaning: S0 nothing matched, S1 "1", S2 "10", S3 "101", S4 "1010", S5 "10100".
module seq_det_arbiter #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [N_CH-1:0]            req_valid,
  input  logic [N_CH-1:0]            req_bit,
  output logic [N_CH-1:0]            req_ready,
  input  logic [N_CH-1:0]            cnt_clr,
  output logic                       tone,
  output logic [$clog2(N_CH)-1:0]    tone_ch,
  output logic [N_CH*CNT_W-1:0]      count,
  output logic [N_CH-1:0]            ovf
);

  localparam int PTR_W = $clog2(N_CH);

  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5} st_t;

  st_t              st [N_CH];
  st_t              st_nxt;
  logic [CNT_W-1:0] cnt [N_CH];
  logic [PTR_W-1:0] ptr, ptr_nxt, gidx;
  logic [N_CH-1:0]  grant;
  logic             found, match, cur_bit;
  int               idx;

  // Search starts at ptr and wraps; first valid channel wins.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    if (en && !rst) begin
      for (int k = 0; k < N_CH; k++) begin
        idx = (int'(ptr) + k) % N_CH;
        if (!found && req_valid[idx]) begin
          found      = 1'b1;
          gidx       = PTR_W'(idx);
          grant[idx] = 1'b1;
        end
      end
    end
  end

  assign req_ready = grant;

  always_comb begin
    st_nxt  = st[gidx];
    cur_bit = req_bit[gidx];
    match   = 1'b0;
    case (st[gidx])
      S0: st_nxt = cur_bit ? S1 : S0;
      S1: st_nxt = cur_bit ? S1 : S2;
      S2: st_nxt = cur_bit ? S3 : S0;
      S3: st_nxt = cur_bit ? S1 : S4;
      S4: st_nxt = cur_bit ? S3 : S5;
      S5: begin
        // Completing match leaves a trailing "1", so resume at S1 for overlap.
        st_nxt = cur_bit ? S1 : S0;
        match  = cur_bit & found;
      end
      default: st_nxt = S0;
    endcase
    ptr_nxt = ptr;
    if (found) ptr_nxt = (int'(gidx) == N_CH - 1) ? '0 : gidx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        st[i]  <= S0;
        cnt[i] <= '0;
      end
      ptr     <= '0;
      tone    <= 1'b0;
      tone_ch <= '0;
      ovf     <= '0;
    end else begin
      if (found) st[gidx] <= st_nxt;
      ptr  <= ptr_nxt;
      tone <= match;
      if (match) tone_ch <= gidx;
      for (int i = 0; i < N_CH; i++) begin
        // A clear coinciding with a match still counts that match.
        if (cnt_clr[i]) begin
          cnt[i] <= (match && int'(gidx) == i) ? CNT_W'(1) : '0;
          ovf[i] <= 1'b0;
        end else if (match && int'(gidx) == i) begin
          cnt[i] <= cnt[i] + 1'b1;
          if (&cnt[i]) ovf[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < N_CH; i++) count[i*CNT_W +: CNT_W] = cnt[i];
  end

endmodule

// File: doc/seq_det_arbiter.md
# seq_det_arbiter

Round-robin scheduler that shares one 101001 sequence-detection engine among N_CH serial bit-stream requesters. Each channel's match progress is saved in a per-channel state register, so the single next-state datapath advances whichever channel is granted in a given cycle. The block emits a one-cycle tone pulse tagged with the channel number on every detected sequence and keeps a per-channel detection count. It sits between the serial stream sources and the tone/count reporting logic.

## Interface
- N_CH, 4: number of requesting channels (2..8).
- CNT_W, 3: width of each per-channel detection counter.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; 0 means no grants are issued.
- req_valid  in  N_CH  channel i has a bit pending.
- req_bit  in  N_CH  pending bit per channel.
- req_ready  out  N_CH  one-hot grant, combinational; a bit is consumed when req_valid[i]&req_ready[i].
- cnt_clr  in  N_CH  clears channel i's counter and overflow flag.
- tone  out  1  one-cycle pulse: a sequence completed.
- tone_ch  out  clog2(N_CH)  channel that completed; valid when tone=1.
- count  out  N_CH*CNT_W  packed per-channel counts; channel i is at bits [i*CNT_W +: CNT_W].
- ovf  out  N_CH  sticky flag; set when channel i's count wraps from all-ones to 0.

## Operation
- **Arbitration**
  - Round-robin with pointer ptr. The grant goes to the first i with req_valid[i], searching ptr, ptr+1, …, modulo N_CH.
  - At most one grant per cycle.
  - req_ready is all zeros when en=0 or no channel is valid.
  - After a grant to channel g, ptr becomes (g+1) mod N_CH. With no grant, ptr holds.
- **Per-channel state** st[i] is in S0..S5 and holds the length of the matched prefix of 1,0,1,0,0,1 (first bit first). Only the granted channel's state updates.
- **Transitions** (in=0 / in=1):
  - S0: S0 / S1
  - S1: S2 / S1
  - S2: S0 / S3
  - S3: S4 / S1
  - S4: S5 / S3
  - S5: S0 / match
- **Match**
  - Reached from S5 with in=1. The channel's next state is S1, so overlapping matches are detected.
  - A match asserts tone, sets tone_ch=g, and increments count[g] modulo 2^CNT_W.
  - A wrap from all-ones to 0 sets ovf[g].
- **Counter clear** (cnt_clr[i]=1)
  - Sets count[i]=0 and ovf[i]=0.
  - If a match on channel i lands in the same cycle, count[i] becomes 1 and ovf[i]=0.
  - Matches on other channels are unaffected.
- **Ungranted channels** keep their state indefinitely. A valid bit held while not granted must stay stable until it is granted.
- **Reset values**: all st=S0, ptr=0, tone=0, tone_ch=0, count=0, ovf=0. req_ready=0 during rst=1.

## Timing
- Grant and consumption happen in the same cycle (combinational req_ready). Throughput is one bit per cycle in total across all channels.
- State, tone, tone_ch, count and ovf are registered.
- A match on the bit consumed at edge k gives tone=1 in the cycle after edge k. count[g] shows the new value from that same cycle.
- tone lasts exactly one cycle unless another match is consumed in the next cycle (back-to-back matches on different channels pulse on consecutive cycles).
- rst asserted mid-sequence discards all partial matches. The next bits after rst deasserts start from S0.
- Toggling en does not alter state or ptr, except that ptr cannot advance while no grants are issued.

## Test plan
- **Single channel, overlap**: channel 0 only, bits 1,0,1,0,0,1,0,1,0,0,1 → tone pulses after the 6th and 11th bits, tone_ch=0, count[0]=2.
- **Round-robin fairness**: all 4 valid continuously, ptr=0 → grants 0,1,2,3,0,1,… each one cycle. Feeding 101001 on every channel gives tone on 4 consecutive cycles with tone_ch=0,1,2,3.
- **Interleaved near-misses**: channel 1 gets 1,0,1,0,1,0,0,1 and channel 2 gets 1,0,0,1 in the gaps → exactly one tone, with tone_ch=1. Channel 2's count stays 0 and its state ends at S1.
- **Wrap and clear**: 8 matches on channel 3 → count[3]=0 and ovf[3]=1. Then cnt_clr[3] pulsed in the same cycle as the 9th match → count[3]=1 and ovf[3]=0.
- **Reset mid-operation**: channel 0 at S5, then rst held for 1 cycle, then bit 1 → no tone and st[0]=S1. All outputs read their reset values in the cycle after rst.
- **Enable gating**: en=0 with all channels valid for 5 cycles → req_ready=0, states, counts and ptr unchanged. Then en=1 → grant to channel ptr.
